// File: rtl/mp_regfile_pkg.sv
// Shared constants, state encoding and address helpers for the mp_regfile block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mp_regfile_pkg;

  // Architectural address map: 0 is the hard-wired zero register, 1..31 are GPRs,
  // 32 is the double-width HI/LO pair, and everything above 32 is unmapped.
  localparam int RF_ZERO_ADDR = 0;
  localparam int RF_HILO_ADDR = 32;

  // Width of the clear sequencer counter; it must be able to hold RF_HILO_ADDR.
  localparam int RF_CNT_W = 6;

  typedef enum logic {
    RF_ST_INIT  = 1'b0,
    RF_ST_READY = 1'b1
  } rf_state_e;

endpackage

// File: rtl/rf_wr_sel.sv
// Write-port arbiter for one query address: returns hit and data of the youngest matching port.
// Latency: purely combinational.
// Backpressure: none; every matching port is considered, losers are silently discarded.
//
// Ports:
//   we_i     NWR write enables
//   waddr_i  NWR packed write addresses, port k at [k*AW +: AW]
//   wdata_i  NWR packed 2*DW write data, port k at [k*2*DW +: 2*DW]
//   qaddr_i  address being queried
//   hit_o    some enabled port targets qaddr_i
//   data_o   data from the highest-index matching port (0 when no hit)
module rf_wr_sel #(
  parameter int NWR = 4,
  parameter int AW  = 6,
  parameter int DW  = 32
) (
  input  logic [NWR-1:0]      we_i,
  input  logic [NWR*AW-1:0]   waddr_i,
  input  logic [NWR*2*DW-1:0] wdata_i,
  input  logic [AW-1:0]       qaddr_i,
  output logic                hit_o,
  output logic [2*DW-1:0]     data_o
);

  // Ascending scan so that a later (younger, higher-index) match overrides an earlier one.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    for (int k = 0; k < NWR; k++) begin
      if (we_i[k] && (waddr_i[k*AW +: AW] == qaddr_i)) begin
        hit_o  = 1'b1;
        data_o = wdata_i[k*2*DW +: 2*DW];
      end
    end
  end

endmodule

// File: rtl/mp_regfile.sv
// Multi-port GPR + HI/LO register file with busy scoreboard and sequenced clear after reset/flush.
// Latency: reads combinational; a write is visible the cycle after its edge (same cycle with RF_BYPASS_EN).
// Backpressure: none; rdy=0 while clearing, during which writes and allocs are dropped.
//
// Ports:
//   clk, resetn           core clock, asynchronous active-low reset
//   clr                   synchronous soft clear (flush / exception restart)
//   rdy                   file initialised and accepting writes/allocs
//   raddr/rdata/rbusy     NRD read ports: address, 2*DW data, busy flag
//   we/waddr/wdata        NWR write ports, higher index has priority
//   alloc_we/alloc_addr   mark a destination register busy
// Optional feature: define RF_BYPASS_EN for same-cycle write->read forwarding.
module mp_regfile
  import mp_regfile_pkg::*;
#(
  parameter int NRD = 16,
  parameter int NWR = 4,
  parameter int AW  = 6,
  parameter int DW  = 32
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                clr,
  output logic                rdy,
  input  logic [NRD*AW-1:0]   raddr,
  output logic [NRD*2*DW-1:0] rdata,
  output logic [NRD-1:0]      rbusy,
  input  logic [NWR-1:0]      we,
  input  logic [NWR*AW-1:0]   waddr,
  input  logic [NWR*2*DW-1:0] wdata,
  input  logic                alloc_we,
  input  logic [AW-1:0]       alloc_addr
);

  localparam int              NENT     = RF_HILO_ADDR;
  localparam logic [AW-1:0]   HILO_A   = AW'(RF_HILO_ADDR);
  // GPR entries only hold DW bits; the upper half is forced to zero on write.
  localparam logic [2*DW-1:0] GPR_MASK = {{DW{1'b0}}, {DW{1'b1}}};

  rf_state_e           state_q, state_d;
  logic [RF_CNT_W-1:0] cnt_q, cnt_d;
  logic                ready;

  logic [2*DW-1:0]     mem_q [1:NENT];
  logic [NENT:1]       busy_q, busy_d;
  logic [NENT:1]       wr_hit;
  logic [2*DW-1:0]     wr_dat [1:NENT];

  assign ready = (state_q == RF_ST_READY);
  assign rdy   = ready;

  // ---------------------------------------------------------------- clear FSM
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= RF_ST_INIT;
      cnt_q   <= RF_CNT_W'(1);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // cnt_q names the entry being cleared on the current edge; the edge that
  // clears HILO (the last entry) is also the one that enters READY.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RF_ST_INIT: begin
        if (clr) begin
          cnt_d = RF_CNT_W'(1);
        end else if (cnt_q == RF_CNT_W'(NENT)) begin
          state_d = RF_ST_READY;
        end else begin
          cnt_d = cnt_q + RF_CNT_W'(1);
        end
      end
      RF_ST_READY: begin
        if (clr) begin
          state_d = RF_ST_INIT;
          cnt_d   = RF_CNT_W'(1);
        end
      end
      default: begin
        state_d = RF_ST_INIT;
        cnt_d   = RF_CNT_W'(1);
      end
    endcase
  end

  // ------------------------------------------------------ write port selection
  for (genvar e = 1; e <= NENT; e++) begin : g_ent
    rf_wr_sel #(.NWR(NWR), .AW(AW), .DW(DW)) u_wr_sel (
      .we_i    (we),
      .waddr_i (waddr),
      .wdata_i (wdata),
      .qaddr_i (AW'(e)),
      .hit_o   (wr_hit[e]),
      .data_o  (wr_dat[e])
    );
  end

  // Array is deliberately not reset; the INIT sequence zeroes it one entry per edge.
  always_ff @(posedge clk) begin
    for (int e = 1; e <= NENT; e++) begin
      if (!ready) begin
        if (cnt_q == RF_CNT_W'(e)) mem_q[e] <= '0;
      end else if (wr_hit[e]) begin
        mem_q[e] <= (e == NENT) ? wr_dat[e] : (wr_dat[e] & GPR_MASK);
      end
    end
  end

  // ------------------------------------------------------------ busy scoreboard
  // Alloc is applied after the write-clear so an alloc+write to one register leaves it busy.
  always_comb begin
    busy_d = busy_q;
    if (!ready || clr) begin
      busy_d = '0;
    end else begin
      busy_d = busy_q & ~wr_hit;
      for (int e = 1; e <= NENT; e++) begin
        if (alloc_we && (alloc_addr == AW'(e))) busy_d[e] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) busy_q <= '0;
    else         busy_q <= busy_d;
  end

  // ----------------------------------------------------------------- read ports
  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [2*DW-1:0] rd;
    logic            rb;

    assign ra = raddr[i*AW +: AW];

`ifdef RF_BYPASS_EN
    logic            byp_hit;
    logic [2*DW-1:0] byp_dat;

    rf_wr_sel #(.NWR(NWR), .AW(AW), .DW(DW)) u_byp_sel (
      .we_i    (we),
      .waddr_i (waddr),
      .wdata_i (wdata),
      .qaddr_i (ra),
      .hit_o   (byp_hit),
      .data_o  (byp_dat)
    );
`endif

    // Addresses 0 and >32 never match an entry, so they fall through to zero.
    always_comb begin
      rd = '0;
      rb = 1'b0;
      if (ready) begin
        for (int e = 1; e <= NENT; e++) begin
          if (ra == AW'(e)) begin
            rd = mem_q[e];
            rb = busy_q[e];
          end
        end
`ifdef RF_BYPASS_EN
        if (byp_hit && (ra != AW'(RF_ZERO_ADDR)) && (ra <= HILO_A)) begin
          rd = (ra == HILO_A) ? byp_dat : (byp_dat & GPR_MASK);
          rb = alloc_we && (alloc_addr == ra);
        end
`endif
      end
    end

    assign rdata[i*2*DW +: 2*DW] = rd;
    assign rbusy[i]              = rb;
  end

endmodule
